// File: rtl/dp_out_collector_pkg.sv
// dp_out_pkg: shared FSM state type and group-select constants for dp_out_collector.
package dp_out_pkg;
    typedef enum logic [1:0] {IDLE, COLLECT, DRAIN} odc_state_t;
    localparam int NGROUPS = 4;
    localparam int SEL_W = 2;
endpackage

// File: rtl/dp_out_collector_fifo.sv
// dp_out_fifo: synchronous FIFO with async active-low reset; head word reads as zero when empty.
module dp_out_fifo #(
    parameter int W = 128,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             wdata,
    output logic [W-1:0]             rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [W-1:0] mem_q [DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [CW-1:0] count_q;
    logic wr, rd;
    assign full  = count_q == CW'(DEPTH);
    assign empty = count_q == '0;
    assign count = count_q;
    assign wr    = push && !full;
    assign rd    = pop && !empty;
    assign rdata = empty ? '0 : mem_q[rptr_q];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wr ? wptr_q + AW'(1) : wptr_q;
            rptr_q  <= rd ? rptr_q + AW'(1) : rptr_q;
            count_q <= count_q + CW'(wr) - CW'(rd);
        end
    end
    always_ff @(posedge clk) begin
        if (wr) mem_q[wptr_q] <= wdata;
    end
endmodule

// File: rtl/dp_out_collector.sv
// dp_out_collector: steps the data-path output mux through 4 groups, queues each word, streams it out.
// Optional DP_OUT_COLLECTOR_PARITY_EN adds per-byte even parity stored alongside each word.
module dp_out_collector
    import dp_out_pkg::*;
#(
    parameter int BW = 128,
    parameter int Pa = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [BW-1:0]    dp_data,
    output logic [SEL_W-1:0] sel_mux_out,
    output logic             wb,
    output logic             busy,
    output logic             done,
    output logic             start_err,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [BW-1:0]    out_data
`ifdef DP_OUT_COLLECTOR_PARITY_EN
    ,
    input  logic             par_inject,
    output logic [BW/8-1:0]  out_parity
`endif
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
`ifdef DP_OUT_COLLECTOR_PARITY_EN
    localparam int FW = BW + BW / 8;
`else
    localparam int FW = BW;
`endif
    odc_state_t state_q, state_d;
    logic [SEL_W-1:0] grp_q, grp_d;
    logic done_q, done_d;
    logic push, pop, full, empty, accept;
    logic [CW-1:0] fifo_count;
    logic [BW-1:0] word;
    logic [FW-1:0] wdata, rdata;
    // Activations pass through untouched, lane p at bits [p*Pa +: Pa].
    always_comb begin
        word = '0;
        for (int p = 0; p < BW / Pa; p++) word[p*Pa +: Pa] = dp_data[p*Pa +: Pa];
    end
`ifdef DP_OUT_COLLECTOR_PARITY_EN
    logic [BW/8-1:0] par;
    always_comb begin
        par = '0;
        for (int b = 0; b < BW / 8; b++) par[b] = ^word[b*8 +: 8];
        par[0] = par[0] ^ par_inject;
    end
    assign wdata      = {par, word};
    assign out_parity = rdata[FW-1:BW];
    assign out_data   = rdata[BW-1:0];
`else
    assign wdata    = word;
    assign out_data = rdata;
`endif
    assign accept      = start && state_q == IDLE && !done_q;
    assign push        = state_q == COLLECT && !full;
    assign pop         = out_valid && out_ready;
    assign out_valid   = !empty;
    assign sel_mux_out = grp_q;
    assign wb          = push;
    assign busy        = state_q != IDLE;
    assign done        = done_q;
    assign start_err   = start && (busy || done_q);
    always_comb begin
        state_d = state_q;
        grp_d   = grp_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                state_d = accept ? COLLECT : IDLE;
                grp_d   = '0;
            end
            COLLECT: begin
                grp_d   = push ? grp_q + SEL_W'(1) : grp_q;
                state_d = (push && grp_q == SEL_W'(NGROUPS - 1)) ? DRAIN : COLLECT;
            end
            DRAIN: begin
                state_d = fifo_count == '0 ? IDLE : DRAIN;
                done_d  = fifo_count == '0;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            grp_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            grp_q   <= grp_d;
            done_q  <= done_d;
        end
    end
    dp_out_fifo #(.W(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .wdata (wdata),
        .rdata (rdata),
        .full  (full),
        .empty (empty),
        .count (fifo_count)
    );
endmodule
